device_peripherals: RTL and testbench
=====================================

# device_peripherals

Memory-mapped peripheral block that sits directly downstream of the CPU's MEM stage on the device bus. It decodes `MemBus_Address` during `Device_Read`/`Device_Write` accesses and returns `Device_Read_Data` to the CPU. It implements a reloading interval timer with an interrupt, an LED register, a 7-segment output register and an optional free-running SysTick counter.

## Interface
Parameters:
- `TIMER_BASE`, default 32'h4000_0000: base address of the peripheral window (TH at +0x00).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `Device_Read`  input  1  CPU read strobe for the current cycle.
- `Device_Write`  input  1  CPU write strobe; the write commits on the next rising edge.
- `MemBus_Address`  input  32  byte address of the access.
- `MemBus_Write_Data`  input  32  write data.
- `Device_Read_Data`  output  32  read data, valid in the same cycle as `Device_Read`.
- `irq`  output  1  timer interrupt request (level).
- `leds`  output  8  LED register.
- `digits`  output  12  7-segment register: [11:8] anode select, [7:0] segments.

## Operation
- Register map (offsets from `TIMER_BASE`):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: count, R/W.
  - 0x08 TCON: R/W. [0] enable, [1] irq enable, [2] irq status. Bits [31:3] read as 0.
  - 0x0C LEDs: [7:0] R/W.
  - 0x10 digits: [11:0] R/W.
  - 0x14 SysTick: read-only.
- Decode uses a full 32-bit compare. Misaligned addresses (`[1:0]≠0`) and addresses outside the map are unmapped: reads return 0 and writes are ignored.
- Read path is combinational: `Device_Read_Data` = the selected register when `Device_Read`=1, otherwise 0.
- Timer behaviour, each cycle with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF: TL ← TH, and if TCON[1]=1 then TCON[2] ← 1.
  - Otherwise TL ← TL+1 (32-bit).
  - With TCON[0]=0, TL holds its value.
- `irq` = TCON[2]. Software clears the interrupt by writing TCON with bit2=0.
- Precedence when a CPU write and a timer update hit the same register in the same cycle: the CPU write wins for the whole register. This covers a TL write during overflow and a TCON write during a status set.
- Simultaneous `Device_Read` and `Device_Write`: the read returns the pre-write value.

## Timing
- All outputs are registered except `Device_Read_Data`, which has 0-cycle latency.
- A write is visible on reads and outputs starting the cycle after the commit edge.
- Overflow: if TL = FFFF_FFFF at edge N, then after edge N, TL = TH and `irq`=1 (when enabled).
- Reset (`reset`=0 at an edge) clears TH, TL, TCON, leds, digits and SysTick to 0, so `irq`=0. Reset wins over any concurrent write or count. Reset asserted mid-count discards the count.

## Configuration
- `DEVICE_SYSTICK_EN` defined:
  - SysTick is a 32-bit counter incremented every cycle out of reset, wrapping FFFF_FFFF→0.
  - Readable at 0x14; writes to 0x14 are ignored.
- `DEVICE_SYSTICK_EN` undefined:
  - No counter is built; 0x14 behaves as unmapped (reads 0).

## Structure
- Shared package `device_pkg`:
  - Register offset constants (TH/TL/TCON/LEDS/DIGITS/SYSTICK).
  - TCON bit indices.
  - Unmapped read value.
- One sub-module, `device_timer`:
  - Holds TH/TL/TCON and overflow/reload logic.
  - Takes decoded write enables and produces `irq`.
- Top level holds address decode, the read mux, LED/digit registers and SysTick.

## Test plan
- Reset then read all six addresses → all return 0; `irq`=0, `leds`=0, `digits`=0.
- Write TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 → TL reaches FFFF_FFFF next cycle; `irq`=1 one cycle later with TL=FFFF_FFFC; write TCON=3 → `irq`=0.
- TCON=1 (irq disabled) through overflow → TL reloads from TH, `irq` stays 0.
- Write TL=5 in the same cycle as overflow → TL=5 afterwards; write TCON=3 in the same cycle as a status set → TCON=3, `irq`=0.
- Write leds=A5, digits=E3F, then read back → A5 and E3F; a write to 0x4000_0018 or 0x4000_0001 changes nothing and reads 0.
- With `DEVICE_SYSTICK_EN`: read 0x14 on two reads 10 cycles apart → difference is 10; pull `reset` low for one cycle → SysTick reads 0 and TL/TCON are cleared.

Source files
------------

// File: rtl/device_pkg.sv
// rtl/device_pkg.sv - register map offsets, TCON bit positions and unmapped read value
package device_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LEDS    = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    localparam logic [31:0] UNMAPPED_READ = 32'h0000_0000;

endpackage

// File: rtl/device_timer.sv
// rtl/device_timer.sv - reloading interval timer (TH/TL/TCON) with level interrupt
module device_timer
    import device_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic overflow;

    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign irq      = tcon[TCON_ST];

    // A CPU write to TL or TCON replaces the whole register, masking any timer update that edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) th <= wdata;

            if (wr_tl)
                tl <= wdata;
            else if (overflow)
                tl <= th;
            else if (tcon[TCON_EN])
                tl <= tl + 32'd1;

            if (wr_tcon)
                tcon <= wdata[2:0];
            else if (overflow && tcon[TCON_IE])
                tcon[TCON_ST] <= 1'b1;
        end
    end

endmodule

// File: rtl/device_peripherals.sv
// rtl/device_peripherals.sv - device bus peripherals: timer, LEDs, digits, SysTick (DEVICE_SYSTICK_EN)
module device_peripherals
    import device_pkg::*;
#(
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Device_Read,
    input  logic        Device_Write,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digits
);

    logic        hit_th, hit_tl, hit_tcon, hit_leds, hit_digits, hit_systick;
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;

    // Full 32-bit compare, so misaligned addresses never alias onto a register.
    assign hit_th      = (MemBus_Address == TIMER_BASE + OFF_TH);
    assign hit_tl      = (MemBus_Address == TIMER_BASE + OFF_TL);
    assign hit_tcon    = (MemBus_Address == TIMER_BASE + OFF_TCON);
    assign hit_leds    = (MemBus_Address == TIMER_BASE + OFF_LEDS);
    assign hit_digits  = (MemBus_Address == TIMER_BASE + OFF_DIGITS);
    assign hit_systick = (MemBus_Address == TIMER_BASE + OFF_SYSTICK);

    device_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (Device_Write && hit_th),
        .wr_tl   (Device_Write && hit_tl),
        .wr_tcon (Device_Write && hit_tcon),
        .wdata   (MemBus_Write_Data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            leds   <= '0;
            digits <= '0;
        end else begin
            if (Device_Write && hit_leds)   leds   <= MemBus_Write_Data[7:0];
            if (Device_Write && hit_digits) digits <= MemBus_Write_Data[11:0];
        end
    end

`ifdef DEVICE_SYSTICK_EN
    always_ff @(posedge clk) begin
        if (!reset) systick <= '0;
        else        systick <= systick + 32'd1;
    end
`else
    assign systick = UNMAPPED_READ;
`endif

    always_comb begin
        Device_Read_Data = UNMAPPED_READ;
        if (Device_Read) begin
            if (hit_th)          Device_Read_Data = th;
            else if (hit_tl)     Device_Read_Data = tl;
            else if (hit_tcon)   Device_Read_Data = {29'd0, tcon};
            else if (hit_leds)   Device_Read_Data = {24'd0, leds};
            else if (hit_digits) Device_Read_Data = {20'd0, digits};
            else if (hit_systick) Device_Read_Data = systick;
        end
    end

endmodule

// File: tb/tb_device_peripherals.sv
// tb/tb_device_peripherals.sv - directed self-checking bench for device_peripherals
module tb_device_peripherals;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Device_Read;
    logic        Device_Write;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic [31:0] Device_Read_Data;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digits;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata, ta, tb_val;

    always #5 clk = ~clk;

    device_peripherals #(.TIMER_BASE(BASE)) dut (
        .clk               (clk),
        .reset             (reset),
        .Device_Read       (Device_Read),
        .Device_Write      (Device_Write),
        .MemBus_Address    (MemBus_Address),
        .MemBus_Write_Data (MemBus_Write_Data),
        .Device_Read_Data  (Device_Read_Data),
        .irq               (irq),
        .leds              (leds),
        .digits            (digits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        Device_Read    = 1'b1;
        MemBus_Address = addr;
        #1;
        data           = Device_Read_Data;
        Device_Read    = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Device_Write      = 1'b1;
        MemBus_Address    = addr;
        MemBus_Write_Data = data;
        step();
        Device_Write      = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        chk(tag, d, exp);
    endtask

    initial begin
        reset = 1'b0;
        Device_Read = 1'b0;
        Device_Write = 1'b0;
        MemBus_Address = '0;
        MemBus_Write_Data = '0;
        step();
        step();
        reset = 1'b1;

        // reset state
        rd_chk("rst_th",      BASE + 32'h00, 32'h0);
        rd_chk("rst_tl",      BASE + 32'h04, 32'h0);
        rd_chk("rst_tcon",    BASE + 32'h08, 32'h0);
        rd_chk("rst_leds",    BASE + 32'h0C, 32'h0);
        rd_chk("rst_digits",  BASE + 32'h10, 32'h0);
        rd_chk("rst_systick", BASE + 32'h14, 32'h0);
        chk("rst_irq",    {31'd0, irq}, 32'h0);
        chk("rst_ledport", {24'd0, leds}, 32'h0);
        chk("rst_digport", {20'd0, digits}, 32'h0);

        // overflow with interrupt enabled
        wr(BASE + 32'h00, 32'hFFFF_FFFC);
        wr(BASE + 32'h04, 32'hFFFF_FFFE);
        wr(BASE + 32'h08, 32'h0000_0003);
        rd_chk("ovf_tl0", BASE + 32'h04, 32'hFFFF_FFFE);
        step();
        rd_chk("ovf_tl1", BASE + 32'h04, 32'hFFFF_FFFF);
        chk("ovf_irq_pre", {31'd0, irq}, 32'h0);
        step();
        rd_chk("ovf_reload", BASE + 32'h04, 32'hFFFF_FFFC);
        chk("ovf_irq", {31'd0, irq}, 32'h1);
        rd_chk("ovf_tcon", BASE + 32'h08, 32'h7);
        wr(BASE + 32'h08, 32'h0000_0003);
        chk("irq_clear", {31'd0, irq}, 32'h0);
        rd_chk("clr_tl", BASE + 32'h04, 32'hFFFF_FFFD);

        // overflow with interrupt disabled
        wr(BASE + 32'h08, 32'h0000_0001);
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        step();
        rd_chk("noirq_reload", BASE + 32'h04, 32'hFFFF_FFFC);
        chk("noirq_irq", {31'd0, irq}, 32'h0);

        // TL write coincident with overflow
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'h0000_0005);
        rd_chk("tl_wr_wins", BASE + 32'h04, 32'h5);

        // TCON write coincident with status set
        wr(BASE + 32'h08, 32'h0000_0003);
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h08, 32'h0000_0003);
        rd_chk("tcon_wr_wins", BASE + 32'h08, 32'h3);
        chk("tcon_wr_irq", {31'd0, irq}, 32'h0);
        rd_chk("tcon_wr_tl", BASE + 32'h04, 32'hFFFF_FFFC);
        step();
        rd_chk("tl_count_on", BASE + 32'h04, 32'hFFFF_FFFD);
        wr(BASE + 32'h08, 32'h0000_0000);
        step();
        rd_chk("tl_hold", BASE + 32'h04, 32'hFFFF_FFFE);
        rd_chk("tcon_upper", BASE + 32'h08, 32'h0);

        // LEDs, digits and unmapped accesses
        wr(BASE + 32'h0C, 32'hFFFF_FFA5);
        wr(BASE + 32'h10, 32'hFFFF_FE3F);
        chk("leds_port", {24'd0, leds}, 32'hA5);
        chk("digits_port", {20'd0, digits}, 32'hE3F);
        rd_chk("leds_rd", BASE + 32'h0C, 32'hA5);
        rd_chk("digits_rd", BASE + 32'h10, 32'hE3F);
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        wr(BASE + 32'h01, 32'hFFFF_FFFF);
        wr(BASE + 32'h0D, 32'h0000_0000);
        chk("unmap_leds", {24'd0, leds}, 32'hA5);
        chk("unmap_digits", {20'd0, digits}, 32'hE3F);
        rd_chk("unmap_rd18", BASE + 32'h18, 32'h0);
        rd_chk("unmap_rd01", BASE + 32'h01, 32'h0);
        rd_chk("unmap_th", BASE + 32'h00, 32'hFFFF_FFFC);

        MemBus_Address = BASE + 32'h0C;
        #1;
        chk("no_read_zero", Device_Read_Data, 32'h0);

        // simultaneous read and write returns the old value
        Device_Read = 1'b1;
        Device_Write = 1'b1;
        MemBus_Address = BASE + 32'h0C;
        MemBus_Write_Data = 32'h0000_003C;
        #1;
        chk("rw_old", Device_Read_Data, 32'hA5);
        step();
        Device_Read = 1'b0;
        Device_Write = 1'b0;
        chk("rw_new", {24'd0, leds}, 32'h3C);

        // SysTick and mid-count reset
`ifdef DEVICE_SYSTICK_EN
        rd(BASE + 32'h14, ta);
        for (int i = 0; i < 10; i++) step();
        rd(BASE + 32'h14, tb_val);
        chk("systick_delta", tb_val - ta, 32'd10);
        wr(BASE + 32'h14, 32'h0000_0000);
        rd(BASE + 32'h14, ta);
        chk("systick_ro", ta - tb_val, 32'd1);
`else
        rd_chk("systick_unmapped", BASE + 32'h14, 32'h0);
`endif
        wr(BASE + 32'h08, 32'h0000_0001);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        rd_chk("rst2_systick", BASE + 32'h14, 32'h0);
        rd_chk("rst2_tl", BASE + 32'h04, 32'h0);
        rd_chk("rst2_tcon", BASE + 32'h08, 32'h0);
        chk("rst2_leds", {24'd0, leds}, 32'h0);
        step();
        rd_chk("rst2_tl_idle", BASE + 32'h04, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
